// File: rtl/debug_slave_cmd_pkg.sv
// Shared FSM state encoding and status bit positions for the debug slave command bridge.
package debug_slave_cmd_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, ISSUE, WAIT_RDY} state_e;

  localparam int ST_OVERRUN = 0;
  localparam int ST_ILLEGAL = 1;
  localparam int ST_TIMEOUT = 2;
endpackage

// File: rtl/debug_toggle_sync.sv
// Synchronises an async toggle into core clock and emits one edge pulse per toggle.
// Latency: SYNC_STAGES clk from toggle to edge_pulse; edges suppressed for SYNC_STAGES+1 clk after reset.
// Backpressure: none, every toggle yields exactly one pulse.
module debug_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tgl,
  output logic edge_pulse
);
  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [WW-1:0]          warm_q;
  logic                   warm_done;

  assign warm_done = (warm_q == WW'(WARM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!warm_done) warm_q <= warm_q + 1'b1;
    end
  end

  // prev_q keeps tracking during warm-up so a toggle line parked high is not seen as an edge
  assign edge_pulse = warm_done && (sync_q[SYNC_STAGES-1] ^ prev_q);
endmodule

// File: rtl/debug_slave_cmd_bridge.sv
// Turns JTAG update-DR/IR toggles into per-channel take_action/take_no_action pulses; optional DBG_CMD_TIMEOUT_EN.
// Latency: SYNC_STAGES+2 clk from udr toggle to pulse when the target channel is ready.
// Backpressure: holds in WAIT_RDY until ch_ready; further commands while busy are dropped and flagged.
module debug_slave_cmd_bridge
  import debug_slave_cmd_pkg::*;
#(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              udr_tgl,
  input  logic              uir_tgl,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic              clr_status,
  output logic [DATA_W-1:0] jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              busy,
  output logic [2:0]        status
);
  localparam int            CH_SPAN  = 1 << IR_W;
  localparam logic [IR_W:0] NUM_CH_L = (IR_W + 1)'(NUM_CH);

  state_e              state_q, state_d;
  logic [IR_W-1:0]     ch_q;
  logic                act_q;
  logic [DATA_W-1:0]   jdo_q;
  logic [2:0]          status_q, status_set;
  logic                udr_edge, uir_edge;
  logic                capture, fire, ch_legal, ch_rdy, timed_out;
  logic [CH_SPAN-1:0]  rdy_ext, ch_sel, act_ext, noact_ext;

  debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk(clk), .reset_n(reset_n), .tgl(udr_tgl), .edge_pulse(udr_edge));
  debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk(clk), .reset_n(reset_n), .tgl(uir_tgl), .edge_pulse(uir_edge));

  // channel space widened to 2**IR_W so an illegal IR never indexes past ch_ready
  assign rdy_ext  = CH_SPAN'(ch_ready);
  assign ch_sel   = CH_SPAN'(1) << ch_q;
  assign ch_legal = ({1'b0, ch_q} < NUM_CH_L);
  assign ch_rdy   = |(rdy_ext & ch_sel);

`ifdef DBG_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wait_cnt_q <= '0;
    else if (state_q != WAIT_RDY) wait_cnt_q <= '0;
    else                          wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timed_out = (state_q == WAIT_RDY) && (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    fire       = 1'b0;
    status_set = '0;
    case (state_q)
      IDLE: if (udr_edge) begin
        capture = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: state_d = ISSUE;
      ISSUE: begin
        if (!ch_legal) begin
          status_set[ST_ILLEGAL] = 1'b1;
          state_d = IDLE;
        end else if (ch_rdy) begin
          fire    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        // abort takes priority, leaving the slot free for a same-cycle new command
        if (uir_edge) begin
          state_d = IDLE;
          if (udr_edge) begin
            capture = 1'b1;
            state_d = CAPTURE;
          end
        end else if (ch_rdy) begin
          fire    = 1'b1;
          state_d = IDLE;
        end else if (timed_out) begin
          status_set[ST_TIMEOUT] = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (udr_edge && (state_q != IDLE) && !capture) status_set[ST_OVERRUN] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      act_q    <= 1'b0;
      jdo_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= (clr_status ? 3'b000 : status_q) | status_set;
      if (capture) begin
        jdo_q <= sr;
        ch_q  <= ir_in;
        act_q <= sr[DATA_W-1];
      end
    end
  end

  assign act_ext        = (fire && act_q)  ? ch_sel : '0;
  assign noact_ext      = (fire && !act_q) ? ch_sel : '0;
  assign take_action    = act_ext[NUM_CH-1:0];
  assign take_no_action = noact_ext[NUM_CH-1:0];
  assign jdo            = jdo_q;
  assign busy           = (state_q != IDLE);
  assign status         = status_q;
endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
// Scoreboard bench for debug_slave_cmd_bridge (NUM_CH=3 so IR value 3 is illegal).
// Timeout scenario is exercised when DBG_CMD_TIMEOUT_EN is defined.
module tb_debug_slave_cmd_bridge;
  localparam int DATA_W = 38;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              udr_tgl = 1'b0;
  logic              uir_tgl = 1'b0;
  logic [1:0]        ir_in = '0;
  logic [DATA_W-1:0] sr = '0;
  logic [2:0]        ch_ready = '0;
  logic              clr_status = 1'b0;
  logic [DATA_W-1:0] jdo;
  logic [2:0]        take_action, take_no_action;
  logic              busy;
  logic [2:0]        status;

  debug_slave_cmd_bridge #(
    .DATA_W(DATA_W), .IR_W(2), .NUM_CH(3), .SYNC_STAGES(2), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .udr_tgl(udr_tgl), .uir_tgl(uir_tgl),
    .ir_in(ir_in), .sr(sr), .ch_ready(ch_ready), .clr_status(clr_status),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    logic              act;
    logic [DATA_W-1:0] dat;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // monitor: every pulse must match the oldest expected command
  exp_t       mon_e;
  int         mon_ch;
  logic [5:0] mon_p;
  always @(negedge clk) begin
    mon_p = {take_action, take_no_action};
    if (reset_n && (mon_p != 6'b0)) begin
      check("pulse_onehot", 64'($countones(mon_p)), 64'd1);
      if (sb.size() == 0) begin
        check("spurious_pulse", 64'(mon_p), 64'd0);
      end else begin
        mon_e  = sb.pop_front();
        mon_ch = -1;
        for (int i = 0; i < 3; i++) if (take_action[i] | take_no_action[i]) mon_ch = i;
        check("pulse_ch", 64'(mon_ch), 64'(mon_e.ch));
        check("pulse_act", 64'(|take_action), 64'(mon_e.act));
        check("pulse_jdo", 64'(jdo), 64'(mon_e.dat));
        if (mon_e.cyc >= 0) check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] ir, input logic act, output logic [DATA_W-1:0] d);
    logic [63:0] r;
    r     = {$urandom, $urandom};
    d     = {act, r[DATA_W-2:0]};
    ir_in = ir;
    sr    = d;
  endtask

  task automatic push(input int ch, input logic act, input logic [DATA_W-1:0] d, input int c);
    exp_t e;
    e.ch = ch; e.act = act; e.dat = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
  endtask

  logic [DATA_W-1:0] d_a, d_b;
  int                c0;

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    tick(3);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_ta", 64'(take_action), 64'd0);
    check("rst_tna", 64'(take_no_action), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    reset_n = 1'b1;
    tick(6);

    // ready channel, action bit set: pulse 4 clk after toggle
    ch_ready = 3'b111;
    load(2'd1, 1'b1, d_a);
    c0 = cyc;
    push(1, 1'b1, d_a, c0 + 4);
    udr_tgl = ~udr_tgl;
    tick(8);
    check("t1_jdo", 64'(jdo), 64'(d_a));
    check("t1_drained", 64'(sb.size()), 64'd0);

    // not-ready channel: wait, then pulse in the cycle ready rises
    ch_ready = 3'b011;
    load(2'd2, 1'b0, d_a);
    c0 = cyc;
    push(2, 1'b0, d_a, c0 + 14);
    udr_tgl = ~udr_tgl;
    tick(10);
    check("t2_busy", 64'(busy), 64'd1);
    tick(4);
    ch_ready = 3'b111;
    tick(3);
    check("t2_idle", 64'(busy), 64'd0);
    check("t2_drained", 64'(sb.size()), 64'd0);

    // overrun while waiting; first command survives
    ch_ready = 3'b011;
    load(2'd2, 1'b1, d_a);
    c0 = cyc;
    push(2, 1'b1, d_a, c0 + 16);
    udr_tgl = ~udr_tgl;
    tick(8);
    load(2'd1, 1'b0, d_b);
    udr_tgl = ~udr_tgl;
    tick(6);
    check("t3_status", 64'(status), 64'b001);
    check("t3_jdo_kept", 64'(jdo), 64'(d_a));
    check("t3_busy", 64'(busy), 64'd1);
    tick(2);
    ch_ready = 3'b111;
    tick(4);
    check("t3_sticky", 64'(status), 64'b001);
    clear_status();
    check("t3_cleared", 64'(status), 64'b000);

    // illegal IR (channel 3 of 3): no pulse, illegal flag, busy ends after ISSUE
    load(2'd3, 1'b1, d_a);
    udr_tgl = ~udr_tgl;
    tick(4);
    @(negedge clk);
    check("t4_busy_issue", 64'(busy), 64'd1);
    @(negedge clk);
    check("t4_busy_done", 64'(busy), 64'd0);
    check("t4_status", 64'(status), 64'b010);
    check("t4_jdo", 64'(jdo), 64'(d_a));
    tick(1);
    clear_status();

    // uir abort from WAIT_RDY: no pulse even once ready
    ch_ready = 3'b011;
    load(2'd2, 1'b1, d_a);
    udr_tgl = ~udr_tgl;
    tick(8);
    uir_tgl = ~uir_tgl;
    tick(6);
    check("t5_abort_idle", 64'(busy), 64'd0);
    ch_ready = 3'b111;
    tick(6);
    check("t5_abort_status", 64'(status), 64'b000);

    // same-cycle uir+udr while waiting: abort then capture the new command
    ch_ready = 3'b011;
    load(2'd2, 1'b0, d_a);
    udr_tgl = ~udr_tgl;
    tick(8);
    load(2'd1, 1'b1, d_b);
    c0 = cyc;
    push(1, 1'b1, d_b, c0 + 4);
    udr_tgl = ~udr_tgl;
    uir_tgl = ~uir_tgl;
    tick(8);
    check("t5_both_drained", 64'(sb.size()), 64'd0);
    check("t5_both_status", 64'(status), 64'b000);
    check("t5_both_jdo", 64'(jdo), 64'(d_b));

    // async reset mid-WAIT_RDY loses the command
    ch_ready = 3'b011;
    load(2'd2, 1'b1, d_a);
    udr_tgl = ~udr_tgl;
    tick(8);
    reset_n = 1'b0;
    #1;
    check("t6_rst_jdo", 64'(jdo), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_pulses", 64'({take_action, take_no_action}), 64'd0);
    check("t6_rst_status", 64'(status), 64'd0);
    tick(2);
    reset_n = 1'b1;
    ch_ready = 3'b111;
    tick(12);
    check("t6_post_busy", 64'(busy), 64'd0);
    check("t6_post_status", 64'(status), 64'd0);

    // normal operation resumes after reset
    load(2'd0, 1'b0, d_a);
    c0 = cyc;
    push(0, 1'b0, d_a, c0 + 4);
    udr_tgl = ~udr_tgl;
    tick(8);
    check("t7_drained", 64'(sb.size()), 64'd0);

`ifdef DBG_CMD_TIMEOUT_EN
    ch_ready = 3'b011;
    load(2'd2, 1'b1, d_a);
    udr_tgl = ~udr_tgl;
    tick(22);
    check("t8_not_yet", 64'(status), 64'b000);
    tick(2);
    check("t8_timeout", 64'(status), 64'b100);
    check("t8_idle", 64'(busy), 64'd0);
    ch_ready = 3'b111;
    tick(4);
    clear_status();
`endif

    check("final_status", 64'(status), 64'd0);
    check("final_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
